sha256_msg_sched: RTL and testbench
===================================

# sha256_msg_sched

SHA-256 message-schedule stage feeding the round/compression datapath. Accepts one 512-bit message block via a valid/ready handshake. Over 64 consecutive cycles it emits Wt and Kt for rounds t = 0..63. It also generates the `soc` and `eoc` strobes that frame one block of compression.

## Interface
- No parameters; word width fixed at 32, rounds fixed at 64.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `blk`  in  512  message block; `blk[511:480]` = W0 … `blk[31:0]` = W15.
- `blk_valid`  in  1  `blk` is valid.
- `blk_ready`  out  1  stage can accept a block; equals (state == IDLE).
- `Wt`  out  32  schedule word for the current round.
- `Kt`  out  32  round constant for the current round.
- `soc`  out  1  one-cycle start-of-compression strobe, coincident with t = 0.
- `eoc`  out  1  one-cycle end-of-compression strobe, the cycle after t = 63.
- `busy`  out  1  high in RUN and FIN.
- `round`  out  6  current t; present only with `SHA256_SCHED_ROUND_EN`.

## Operation
- States:
  - IDLE → RUN on `blk_valid & blk_ready`.
  - RUN → FIN when t == 63.
  - FIN → IDLE unconditionally.
- Capture: on the accepting edge, load a 16-word window `w[0..15]` with W0..W15 and clear t to 0.
- RUN, each cycle:
  - `Wt = w[0]`; `Kt = K[t]`.
  - On the clock edge, shift the window: `w[i] ← w[i+1]`, and `w[15] ← σ1(w[14]) + w[9] + σ0(w[1]) + w[0]` (mod 2^32, carries discarded).
  - Increment t.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3. σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- The window advances every RUN cycle, including t ≥ 48. Words computed past W63 are discarded.
- `Wt` and `Kt` are forced to 0 outside RUN.
- `blk_valid` is ignored outside IDLE. No back-pressure from downstream: the compression stage consumes one round per cycle.
- `blk` need not be held after acceptance.

## Timing
- Reset values:
  - State IDLE, t = 0, window all zero.
  - `Wt` = 0, `Kt` = 0, `soc` = 0, `eoc` = 0, `busy` = 0, `round` = 0.
  - `blk_ready` = 1 during and after reset. No capture occurs while `rst` is high.
- Block accepted at edge N:
  - `soc` = 1 and t = 0 in cycle N+1.
  - t = 63 in cycle N+64.
  - `eoc` = 1 in cycle N+65 (FIN).
  - `blk_ready` = 1 again in cycle N+66.
- Minimum block-to-block spacing is 66 cycles.
- `soc` and `eoc` are each high for exactly one cycle per block and are never high together.
- `rst` asserted mid-block: all state clears immediately and asynchronously. No `eoc` is produced for the aborted block.
- `blk_valid` held continuously: the next block is accepted on the first IDLE cycle.

## Configuration
- Macro `SHA256_SCHED_ROUND_EN`.
- Defined: the `round` output port exists. It carries t during RUN, holds 63 in FIN, and is 0 in IDLE.
- Undefined: the port is absent. The internal counter and all other behaviour are unchanged.

## Structure
- Shared package `sha256_pkg` holds:
  - the 64-entry K constant array;
  - the state enum (IDLE, RUN, FIN);
  - the σ0/σ1 functions;
  - the IV constants reused by the compression stage.
- Single sub-module `sha256_kt_rom`: a 6-bit index maps combinationally to a 32-bit K[t].

## Test plan
- Reset check: assert `rst` → `blk_ready` = 1 and all other outputs 0. Release `rst` with `blk_valid` = 0 → no `soc` for 100 cycles.
- "abc" block: W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018. Required response:
  - `soc` in cycle N+1 with `Wt` = 0x61626380 and `Kt` = 0x428a2f98.
  - W16 = 0x61626380 and W17 = 0x000F0000.
  - `Kt` at t = 63 = 0xc67178f2.
  - `eoc` at N+65.
- Random blocks: 200 random `blk` values with `Wt` checked against a reference model for all 64 rounds → zero mismatches. Exactly one `soc` and one `eoc` per block.
- Back-to-back: `blk_valid` held high with two distinct blocks → second accepted exactly 66 cycles after the first. `blk` changes while `busy` have no effect on `Wt`.
- Mid-block reset: assert `rst` at t = 30 → outputs return to 0 asynchronously and no `eoc` appears. A new block afterwards produces the correct W0..W63.
- `SHA256_SCHED_ROUND_EN` build: `round` counts 0..63 in step with `Kt`, reads 63 during `eoc`, and reads 0 in IDLE.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash values, schedule
// state encoding and the small-sigma functions used by the message schedule.
package sha256_pkg;

    localparam int unsigned ROUNDS     = 64;
    localparam logic [5:0]  LAST_ROUND = 6'd63;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } sched_state_e;

    localparam logic [31:0] K [ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Initial hash value H0..H7, consumed by the compression stage.
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_kt_rom.sv
// Combinational round-constant lookup: 6-bit round index to K[t].
module sha256_kt_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  idx,
    output logic [31:0] kt
);

    assign kt = K[idx];

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: accepts a 512-bit block and streams Wt/Kt for 64
// rounds with soc/eoc framing. Optional `round` port under SHA256_SCHED_ROUND_EN.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] blk,
    input  logic         blk_valid,
    output logic         blk_ready,
    output logic [31:0]  Wt,
    output logic [31:0]  Kt,
    output logic         soc,
    output logic         eoc,
    output logic         busy
`ifdef SHA256_SCHED_ROUND_EN
   ,output logic [5:0]   round
`endif
);

    sched_state_e state, state_nxt;
    logic [5:0]   t;
    logic [31:0]  w [16];
    logic [31:0]  k_word;
    logic [31:0]  w_new;
    logic         accept;

    assign accept = blk_valid & blk_ready;
    assign w_new  = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

    // NOTE: state registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (t == LAST_ROUND) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // t saturates at 63 so it still reads 63 during FIN, then clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= '0;
        end else if (state == RUN) begin
            if (t != LAST_ROUND) t <= t + 6'd1;
        end else begin
            t <= '0;
        end
    end

    // NOTE: the window is reset explicitly; it is a register file, not a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < 16; i++) w[i] <= blk[511-32*i -: 32];
        end else if (state == RUN) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_new;
        end
    end

    sha256_kt_rom u_kt_rom (
        .idx (t),
        .kt  (k_word)
    );

    assign blk_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign soc       = (state == RUN) && (t == 6'd0);
    assign eoc       = (state == FIN);
    assign Wt        = (state == RUN) ? w[0]   : '0;
    assign Kt        = (state == RUN) ? k_word : '0;

`ifdef SHA256_SCHED_ROUND_EN
    assign round = t;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: directed "abc", random blocks, back-to-back and
// mid-block reset, checked against a whole-block schedule model.
module tb_sha256_msg_sched;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] blk;
    logic         blk_valid;
    logic         blk_ready;
    logic [31:0]  Wt;
    logic [31:0]  Kt;
    logic         soc;
    logic         eoc;
    logic         busy;
`ifdef SHA256_SCHED_ROUND_EN
    logic [5:0]   round;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] ref_w [64];
    logic [31:0] obs_w [64];
    logic [31:0] obs_k [64];

    sha256_msg_sched dut (
        .clk       (clk),
        .rst       (rst),
        .blk       (blk),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .Wt        (Wt),
        .Kt        (Kt),
        .soc       (soc),
        .eoc       (eoc),
        .busy      (busy)
`ifdef SHA256_SCHED_ROUND_EN
       ,.round     (round)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule computed for the whole block at once.
    task automatic fill_ref(input logic [511:0] b);
        for (int i = 0; i < 16; i++) ref_w[i] = b[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            ref_w[i] = (rotr(ref_w[i-2], 17) ^ rotr(ref_w[i-2], 19) ^ (ref_w[i-2] >> 10))
                     + ref_w[i-7]
                     + (rotr(ref_w[i-15], 7) ^ rotr(ref_w[i-15], 18) ^ (ref_w[i-15] >> 3))
                     + ref_w[i-16];
        end
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] r = '0;
        for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom())};
        return r;
    endfunction

    // Called at the negedge where soc is due; walks rounds, FIN and return to IDLE.
    task automatic expect_block(input logic [511:0] b, input logic [511:0] junk,
                                input bit hold_valid, output int soc_cyc);
        fill_ref(b);
        soc_cyc = cyc;
        for (int t = 0; t < 64; t++) begin
            if (t > 0) @(negedge clk);
            obs_w[t] = Wt;
            obs_k[t] = Kt;
            check("Wt", Wt, ref_w[t]);
            check("Kt", Kt, K_TAB[t]);
            check("soc", 32'(soc), 32'(t == 0));
            check("eoc_in_run", 32'(eoc), 0);
            check("busy_in_run", 32'(busy), 1);
`ifdef SHA256_SCHED_ROUND_EN
            check("round_in_run", 32'(round), 32'(t));
`endif
            if (t == 0) begin
                blk = junk;
                if (!hold_valid) blk_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("eoc_fin", 32'(eoc), 1);
        check("soc_fin", 32'(soc), 0);
        check("Wt_fin", Wt, 0);
        check("Kt_fin", Kt, 0);
        check("busy_fin", 32'(busy), 1);
        check("ready_fin", 32'(blk_ready), 0);
`ifdef SHA256_SCHED_ROUND_EN
        check("round_fin", 32'(round), 63);
`endif
        @(negedge clk);
        check("ready_idle", 32'(blk_ready), 1);
        check("busy_idle", 32'(busy), 0);
        check("eoc_idle", 32'(eoc), 0);
        check("Wt_idle", Wt, 0);
`ifdef SHA256_SCHED_ROUND_EN
        check("round_idle", 32'(round), 0);
`endif
    endtask

    task automatic run_block(input logic [511:0] b);
        int sc;
        blk       = b;
        blk_valid = 1'b1;
        @(negedge clk);
        expect_block(b, rand_blk(), 1'b0, sc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] blk_a, blk_b;
        int ca, cb, n_soc, n_eoc, n_busy;

        // Reset with a valid block offered: nothing may be captured.
        rst       = 1'b1;
        blk_valid = 1'b1;
        blk       = rand_blk();
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(blk_ready), 1);
        check("rst_Wt", Wt, 0);
        check("rst_Kt", Kt, 0);
        check("rst_soc", 32'(soc), 0);
        check("rst_eoc", 32'(eoc), 0);
        check("rst_busy", 32'(busy), 0);
`ifdef SHA256_SCHED_ROUND_EN
        check("rst_round", 32'(round), 0);
`endif
        blk_valid = 1'b0;
        rst       = 1'b0;
        n_soc = 0; n_busy = 0;
        repeat (100) begin
            @(negedge clk);
            n_soc  += 32'(soc);
            n_busy += 32'(busy);
        end
        check("idle_soc_count", n_soc, 0);
        check("idle_busy_count", n_busy, 0);

        // "abc" single-block message.
        blk_a = {32'h61626380, {14{32'h0}}, 32'h00000018};
        run_block(blk_a);
        check("abc_w0", obs_w[0], 32'h61626380);
        check("abc_k0", obs_k[0], 32'h428a2f98);
        check("abc_w16", obs_w[16], 32'h61626380);
        check("abc_w17", obs_w[17], 32'h000f0000);
        check("abc_k63", obs_k[63], 32'hc67178f2);

        // Random blocks.
        for (int n = 0; n < 200; n++) begin
            run_block(rand_blk());
            if (($urandom() & 3) == 0) @(negedge clk);
        end

        // Back-to-back with blk_valid held; blk swapped to B while A runs.
        blk_a     = rand_blk();
        blk_b     = rand_blk();
        blk       = blk_a;
        blk_valid = 1'b1;
        @(negedge clk);
        expect_block(blk_a, blk_b, 1'b1, ca);
        @(negedge clk);
        expect_block(blk_b, rand_blk(), 1'b0, cb);
        check("b2b_spacing", cb - ca, 66);

        // Mid-block reset at t = 30.
        blk_a     = rand_blk();
        fill_ref(blk_a);
        blk       = blk_a;
        blk_valid = 1'b1;
        @(negedge clk);
        check("mid_soc", 32'(soc), 1);
        blk_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_w30", Wt, ref_w[30]);
        rst = 1'b1;
        #1;
        check("mid_rst_Wt", Wt, 0);
        check("mid_rst_Kt", Kt, 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(blk_ready), 1);
        check("mid_rst_eoc", 32'(eoc), 0);
`ifdef SHA256_SCHED_ROUND_EN
        check("mid_rst_round", 32'(round), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        n_soc = 0; n_eoc = 0;
        repeat (80) begin
            @(negedge clk);
            n_soc += 32'(soc);
            n_eoc += 32'(eoc);
        end
        check("mid_no_eoc", n_eoc, 0);
        check("mid_no_soc", n_soc, 0);
        run_block(rand_blk());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
